rx_sample_packer: RTL and testbench

Serialises decimated baseband samples into the 16-bit RX FIFO word stream. Sits directly downstream of two `rx_chain` instances (channel 0 and channel 1). On each decimator strobe it captures their I/Q outputs and writes them to the RX FIFO write port one word per cycle, in the order ch0 I, ch0 Q, ch1 I, ch1 Q, skipping disabled channels. It stalls on FIFO full and flags overruns when a new strobe arrives before the previous burst has drained.

---
 rtl/rx_pack_pkg.sv | 23 ++
 rtl/rx_pack_next_idx.sv | 32 +++
 rtl/rx_sample_packer.sv | 126 ++++++++++++
 tb/tb_rx_sample_packer.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_pack_pkg.sv
// Shared types and constants for the RX sample packer: FSM states, word
// indices in FIFO order, and the per-word enable map derived from a channel mask.
package rx_pack_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  localparam int NUM_WORDS = 4;
  localparam int IDX_W     = 2;

  localparam logic [IDX_W-1:0] W_CH0I = 2'd0;
  localparam logic [IDX_W-1:0] W_CH0Q = 2'd1;
  localparam logic [IDX_W-1:0] W_CH1I = 2'd2;
  localparam logic [IDX_W-1:0] W_CH1Q = 2'd3;

  // Each channel contributes its I and Q word; bit k set means word k is sent.
  function automatic logic [NUM_WORDS-1:0] word_enables(input logic [1:0] mask);
    return {mask[1], mask[1], mask[0], mask[0]};
  endfunction

endpackage

// File: rtl/rx_pack_next_idx.sv
// Combinational next-enabled-word search: the first enabled word after idx (wrapping),
// plus a flag that idx holds the last enabled word of the burst. Zero latency.
module rx_pack_next_idx
  import rx_pack_pkg::*;
(
  input  logic [IDX_W-1:0] idx,
  input  logic [1:0]       mask,
  output logic [IDX_W-1:0] next_idx,
  output logic             last
);

  logic [NUM_WORDS-1:0] en;

  always_comb begin
    en       = word_enables(mask);
    next_idx = idx;
    last     = 1'b1;
    // Wrapped candidates first, so that any word strictly after idx overrides them.
    for (int k = NUM_WORDS - 1; k >= 0; k--) begin
      if (en[k] && (k <= int'(idx))) begin
        next_idx = IDX_W'(k);
      end
    end
    for (int k = NUM_WORDS - 1; k >= 0; k--) begin
      if (en[k] && (k > int'(idx))) begin
        next_idx = IDX_W'(k);
        last     = 1'b0;
      end
    end
  end

endmodule

// File: rtl/rx_sample_packer.sv
// Packs strobed ch0/ch1 I/Q samples into 16-bit RX FIFO writes, one word per cycle.
// First write the cycle after the strobe; fifo_full stalls in place; strobes while busy count as overruns.
module rx_sample_packer
  import rx_pack_pkg::*;
#(
  parameter int OVR_CNT_W = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [1:0]           chan_mask,
  input  logic                 strobe,
  input  logic [15:0]          ch0_i,
  input  logic [15:0]          ch0_q,
  input  logic [15:0]          ch1_i,
  input  logic [15:0]          ch1_q,
  input  logic                 fifo_full,
  output logic                 fifo_wr,
  output logic [15:0]          fifo_data,
  output logic                 busy,
  output logic                 overrun,
  input  logic                 overrun_clr,
  output logic [OVR_CNT_W-1:0] ovr_count
);

  state_t           state;
  state_t           state_nxt;
  logic [15:0]      hold [NUM_WORDS];
  logic [1:0]       mask_q;
  logic [IDX_W-1:0] idx;

  logic [IDX_W-1:0] first_idx;
  logic             first_last_unused;
  logic [IDX_W-1:0] adv_idx;
  logic             adv_last;

  logic             final_wr;
  logic             accept;
  logic             ovr_ev;

  // Searching forward from the last word wraps round to the first enabled word.
  rx_pack_next_idx u_first_idx (
    .idx      (W_CH1Q),
    .mask     (chan_mask),
    .next_idx (first_idx),
    .last     (first_last_unused)
  );

  rx_pack_next_idx u_adv_idx (
    .idx      (idx),
    .mask     (mask_q),
    .next_idx (adv_idx),
    .last     (adv_last)
  );

  always_comb begin
    final_wr = fifo_wr & adv_last;
    accept   = strobe & enable & (chan_mask != 2'b00) & ((state == IDLE) | final_wr);
    ovr_ev   = strobe & enable & (state == SEND) & ~final_wr;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (!enable) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (accept) state_nxt = SEND;
        SEND:    if (final_wr && !accept) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    busy      = (state == SEND);
    fifo_wr   = (state == SEND) & enable & ~fifo_full;
    fifo_data = (state == SEND) ? hold[idx] : 16'h0000;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < NUM_WORDS; k++) begin
        hold[k] <= 16'h0000;
      end
      mask_q <= 2'b00;
      idx    <= W_CH0I;
    end else if (accept) begin
      hold[W_CH0I] <= ch0_i;
      hold[W_CH0Q] <= ch0_q;
      hold[W_CH1I] <= ch1_i;
      hold[W_CH1Q] <= ch1_q;
      mask_q       <= chan_mask;
      idx          <= first_idx;
    end else if (fifo_wr && !adv_last) begin
      idx <= adv_idx;
    end
  end

  // A dropped strobe outranks a coincident clear, restarting the count at one.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      overrun   <= 1'b0;
      ovr_count <= '0;
    end else if (ovr_ev) begin
      overrun <= 1'b1;
      if (overrun_clr) begin
        ovr_count <= OVR_CNT_W'(1);
      end else if (!(&ovr_count)) begin
        ovr_count <= ovr_count + 1'b1;
      end
    end else if (overrun_clr) begin
      overrun   <= 1'b0;
      ovr_count <= '0;
    end
  end

endmodule

// File: tb/tb_rx_sample_packer.sv
// Bench for rx_sample_packer: directed burst table, hand-written stall/overrun/enable/reset
// sequences, then randomized traffic against a queue-based reference model.
module tb_rx_sample_packer;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic [1:0]  chan_mask;
  logic        strobe;
  logic [15:0] ch0_i, ch0_q, ch1_i, ch1_q;
  logic        fifo_full;
  logic        overrun_clr;
  logic        fifo_wr;
  logic [15:0] fifo_data;
  logic        busy;
  logic        overrun;
  logic [15:0] ovr_count;

  int checks   = 0;
  int failures = 0;

  logic [15:0] got_q[$];

  localparam logic [3:0][15:0] BURST = {16'hDEF0, 16'h9ABC, 16'h5678, 16'h1234};

  typedef struct {
    logic [1:0]       mask;
    logic [3:0][15:0] w;
    int               n;
    logic [3:0][15:0] e;
    string            tag;
  } vec_t;

  vec_t vecs[4];

  always #5 clock = ~clock;

  rx_sample_packer #(.OVR_CNT_W(16)) dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .chan_mask   (chan_mask),
    .strobe      (strobe),
    .ch0_i       (ch0_i),
    .ch0_q       (ch0_q),
    .ch1_i       (ch1_i),
    .ch1_q       (ch1_q),
    .fifo_full   (fifo_full),
    .fifo_wr     (fifo_wr),
    .fifo_data   (fifo_data),
    .busy        (busy),
    .overrun     (overrun),
    .overrun_clr (overrun_clr),
    .ovr_count   (ovr_count)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_samples(input logic [3:0][15:0] w);
    ch0_i = w[0];
    ch0_q = w[1];
    ch1_i = w[2];
    ch1_q = w[3];
  endtask

  task automatic check_words(input string tag, input logic [7:0][15:0] e, input int n);
    check({tag, "_count"}, got_q.size(), n);
    for (int i = 0; i < n && i < got_q.size(); i++) begin
      check($sformatf("%s_word%0d", tag, i), got_q[i], e[i]);
    end
  endtask

  // Cycle 0 is the first scheduled cycle; bit c of each vector drives that cycle.
  task automatic run_sched(input logic [15:0] stb, input logic [15:0] full,
                           input logic [15:0] clr, input int ncyc, output logic [15:0] wrm);
    wrm = '0;
    got_q.delete();
    for (int c = 0; c < ncyc; c++) begin
      strobe      = stb[c];
      fifo_full   = full[c];
      overrun_clr = clr[c];
      #1;
      if (fifo_wr) begin
        wrm[c] = 1'b1;
        got_q.push_back(fifo_data);
      end
      tick();
    end
    strobe      = 1'b0;
    fifo_full   = 1'b0;
    overrun_clr = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int first_c;
    int last_c;
    first_c = -1;
    last_c  = -1;
    got_q.delete();
    chan_mask = v.mask;
    set_samples(v.w);
    strobe = 1'b1;
    tick();
    strobe    = 1'b0;
    chan_mask = ~v.mask;
    for (int c = 1; c <= 8; c++) begin
      #1;
      if (fifo_wr) begin
        got_q.push_back(fifo_data);
        if (first_c < 0) first_c = c;
        last_c = c;
      end
      tick();
    end
    check_words(v.tag, {64'h0, v.e}, v.n);
    if (v.n > 0) begin
      check({v.tag, "_first_cycle"}, first_c, 1);
      check({v.tag, "_last_cycle"}, last_c, v.n);
    end
    check({v.tag, "_busy_end"}, busy, 1'b0);
    check({v.tag, "_no_overrun"}, overrun, 1'b0);
  endtask

  task automatic clear_overrun();
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
  endtask

  initial begin
    logic [15:0]  wrm;
    logic [15:0]  pq[$];
    logic         m_ovr;
    int           m_cnt;
    logic         exp_wr;
    logic         was_busy;
    logic         fin;
    logic         ev;

    vecs[0] = '{2'b11, BURST, 4, BURST, "m11"};
    vecs[1] = '{2'b10, {16'hFFFF, 16'h0001, 16'hBBBB, 16'hAAAA}, 2,
                {16'h0000, 16'h0000, 16'hFFFF, 16'h0001}, "m10"};
    vecs[2] = '{2'b01, {16'h4444, 16'h3333, 16'h2222, 16'h1111}, 2,
                {16'h0000, 16'h0000, 16'h2222, 16'h1111}, "m01"};
    vecs[3] = '{2'b00, {16'h7777, 16'h6666, 16'h5555, 16'h4444}, 0,
                {16'h0000, 16'h0000, 16'h0000, 16'h0000}, "m00"};

    reset       = 1'b0;
    enable      = 1'b1;
    chan_mask   = 2'b11;
    strobe      = 1'b0;
    fifo_full   = 1'b0;
    overrun_clr = 1'b0;
    set_samples(BURST);
    repeat (3) tick();
    check("rst_fifo_wr", fifo_wr, 1'b0);
    check("rst_fifo_data", fifo_data, 16'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    check("rst_ovr_count", ovr_count, 16'h0);
    reset = 1'b1;
    tick();

    for (int i = 0; i < 4; i++) begin
      run_vec(vecs[i]);
    end

    // Back-pressure across the middle of a burst.
    chan_mask = 2'b11;
    set_samples(BURST);
    run_sched(16'h0001, 16'h001C, 16'h0000, 10, wrm);
    check("stall_wr_cycles", wrm, 16'h00E2);
    check_words("stall", {64'h0, BURST}, 4);

    // Strobe two cycles into a 4-word burst is dropped.
    run_sched(16'h0005, 16'h0000, 16'h0000, 8, wrm);
    check("ovr2_wr_cycles", wrm, 16'h001E);
    check_words("ovr2", {64'h0, BURST}, 4);
    check("ovr2_flag", overrun, 1'b1);
    check("ovr2_count", ovr_count, 16'd1);
    clear_overrun();
    check("clr_flag", overrun, 1'b0);
    check("clr_count", ovr_count, 16'd0);

    // Strobe on the final write chains straight into the next burst.
    run_sched(16'h0011, 16'h0000, 16'h0000, 12, wrm);
    check("b2b_wr_cycles", wrm, 16'h01FE);
    check_words("b2b", {BURST, BURST}, 8);
    check("b2b_no_overrun", overrun, 1'b0);

    // Two drops, the second coincident with a clear: the drop wins.
    run_sched(16'h0007, 16'h0000, 16'h0004, 8, wrm);
    check("clr_race_flag", overrun, 1'b1);
    check("clr_race_count", ovr_count, 16'd1);
    clear_overrun();

    // Saturation: hold the FIFO full and strobe every cycle.
    strobe    = 1'b1;
    fifo_full = 1'b1;
    tick();
    for (int i = 1; i <= 70000; i++) begin
      tick();
      if (i == 65534) check("sat_below", ovr_count, 16'hFFFE);
    end
    check("sat_count", ovr_count, 16'hFFFF);
    check("sat_flag", overrun, 1'b1);
    strobe    = 1'b0;
    fifo_full = 1'b0;
    repeat (6) tick();
    clear_overrun();

    // Enable drop after the second word; a drop at cycle 1 sets the sticky flag.
    got_q.delete();
    strobe = 1'b1;
    tick();
    for (int c = 1; c <= 2; c++) begin
      strobe = (c == 1);
      #1;
      if (fifo_wr) got_q.push_back(fifo_data);
      tick();
    end
    check_words("en_pre", {64'h0, BURST}, 2);
    enable = 1'b0;
    #1;
    check("en_drop_wr", fifo_wr, 1'b0);
    tick();
    check("en_drop_busy", busy, 1'b0);
    check("en_drop_ovr_held", overrun, 1'b1);
    enable = 1'b1;
    wrm = '0;
    for (int c = 0; c < 4; c++) begin
      #1;
      if (fifo_wr) wrm[c] = 1'b1;
      tick();
    end
    check("en_drop_no_resume", wrm, 16'h0);
    clear_overrun();

    // Asynchronous reset mid-burst, then a clean burst afterwards.
    strobe = 1'b1;
    tick();
    strobe = 1'b0;
    tick();
    strobe = 1'b1;
    tick();
    strobe = 1'b0;
    check("pre_rst_ovr", overrun, 1'b1);
    #1;
    reset = 1'b0;
    #1;
    check("arst_wr", fifo_wr, 1'b0);
    check("arst_data", fifo_data, 16'h0);
    check("arst_busy", busy, 1'b0);
    check("arst_overrun", overrun, 1'b0);
    check("arst_count", ovr_count, 16'h0);
    tick();
    reset = 1'b1;
    tick();
    run_vec(vecs[0]);

    // Randomized traffic against the queue model.
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    pq.delete();
    m_ovr = 1'b0;
    m_cnt = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      strobe      = ($urandom_range(0, 99) < 35);
      fifo_full   = ($urandom_range(0, 99) < 20);
      enable      = ($urandom_range(0, 99) < 96);
      overrun_clr = ($urandom_range(0, 99) < 3);
      chan_mask   = 2'($urandom_range(0, 3));
      ch0_i       = 16'($urandom);
      ch0_q       = 16'($urandom);
      ch1_i       = 16'($urandom);
      ch1_q       = 16'($urandom);
      #1;
      was_busy = (pq.size() != 0);
      exp_wr   = enable && was_busy && !fifo_full;
      check("rnd_wr", fifo_wr, exp_wr);
      check("rnd_busy", busy, was_busy);
      check("rnd_overrun", overrun, m_ovr);
      check("rnd_count", ovr_count, m_cnt);
      if (exp_wr && fifo_wr) check("rnd_data", fifo_data, pq[0]);

      ev = 1'b0;
      if (!enable) begin
        pq.delete();
      end else begin
        fin = exp_wr && (pq.size() == 1);
        if (exp_wr) void'(pq.pop_front());
        if (strobe) begin
          if (was_busy && !fin) begin
            ev = 1'b1;
          end else begin
            if (chan_mask[0]) begin
              pq.push_back(ch0_i);
              pq.push_back(ch0_q);
            end
            if (chan_mask[1]) begin
              pq.push_back(ch1_i);
              pq.push_back(ch1_q);
            end
          end
        end
      end
      if (ev) begin
        m_ovr = 1'b1;
        if (overrun_clr) m_cnt = 1;
        else if (m_cnt < 65535) m_cnt = m_cnt + 1;
      end else if (overrun_clr) begin
        m_ovr = 1'b0;
        m_cnt = 0;
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
